// File: rtl/l2_burst_adaptor.sv
// Splits single-cycle cache line transfers into fixed-length beat bursts on the
// memory port, and reassembles read beats into a registered line for the cache.
module l2_burst_adaptor #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int num_beats = s_line / s_burst
) (
  input  logic                clk,
  input  logic                rst,
  // cache side
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  output logic                resp_o,
  // memory side
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [s_burst-1:0]  burst_o,
  input  logic [s_burst-1:0]  burst_i,
  input  logic                resp_i
);

  localparam int CNT_W = $clog2(num_beats);
  localparam int OFF_W = $clog2(s_line / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(num_beats - 1);
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [s_line-1:0]   line_q, line_d;
  logic [s_line-1:0]   buf_q, buf_d;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned
    // and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    buf_d   = buf_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write-back wins a tie so a dirty victim leaves before its refill.
        if (write_i || read_i) begin
          state_d = write_i ? WRITE : READ;
          addr_d  = address_i & LINE_MASK;
          cnt_d   = '0;
          if (write_i) buf_d = line_i;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together
  // from values sampled at the same edge. The line and write buffers are plain
  // registers (not a RAM), so they are cleared on reset like the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
    end
  end

  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = buf_q[int'(cnt_q)*s_burst +: s_burst];

endmodule
